// File: rtl/exp_input_pkg.sv
// Shared constants for the expansion-bus input responder: event bit map,
// expansion register indices and the startup state encoding.
package exp_input_pkg;

    localparam int EVT_PRESS_LSB   = 0;
    localparam int EVT_RELEASE_LSB = 3;
    localparam int EVT_SW_CHANGE   = 6;
    localparam int EVT_W           = 7;

    localparam logic [3:0] EDR_INPUT_LEVEL = 4'h0;
    localparam logic [3:0] EDR_INPUT_EVENT = 4'h1;
    localparam logic [3:0] EDR_INPUT_MASK  = 4'h2;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } startup_state_e;

    function automatic logic any_pending(input logic [EVT_W-1:0] evt,
                                         input logic [EVT_W-1:0] mask);
        return |(evt & mask);
    endfunction

endpackage

// File: rtl/exp_input_responder_debounce_cell.sv
// One input: 2-flop synchronizer, tick-counting debounce and a one-cycle
// rise/fall strobe that coincides with the cycle the stable value flips.
module debounce_cell
    import exp_input_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 10,
    parameter bit INVERT         = 1'b0
) (
    input  logic sysclk,
    input  logic sysreset_n,
    input  logic pulse1k,
    input  logic run,
    input  logic load,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          synced_s;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stable_q;
    logic          stable_d;
    logic          accept_s;

    // Synchronizer stages run in every state so they are full before LOAD.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    assign synced_s = sync2_q ^ INVERT;

    // Debounce: any agreeing cycle clears the count; ticks with disagreement advance it.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept_s = 1'b0;
        if (load) begin
            stable_d = synced_s;
            cnt_d    = {CW{1'b0}};
        end else if (!run) begin
            cnt_d = {CW{1'b0}};
        end else if (synced_s == stable_q) begin
            cnt_d = {CW{1'b0}};
        end else if (pulse1k) begin
            if (cnt_q == CNT_LAST) begin
                accept_s = 1'b1;
                stable_d = synced_s;
                cnt_d    = {CW{1'b0}};
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and stable value registers.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            cnt_q    <= {CW{1'b0}};
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;
    assign rise   = accept_s & synced_s;
    assign fall   = accept_s & ~synced_s;

endmodule

// File: rtl/exp_input_responder.sv
// Expansion-bus responder for DE0 pushbuttons and slide switches: debounced
// levels, sticky clear-on-read events, event mask and a pending flag.
module exp_input_responder
    import exp_input_pkg::*;
#(
    parameter int NUM_BTN        = 3,
    parameter int NUM_SW         = 10,
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic               sysclk,
    input  logic               sysreset_n,
    input  logic               pulse1k,
    input  logic [NUM_BTN-1:0] buttons_raw,
    input  logic [NUM_SW-1:0]  switches_raw,
    input  logic [15:0]        data_in,
    output logic [15:0]        level_out,
    output logic [15:0]        event_out,
    input  logic               event_read,
    output logic [15:0]        mask_out,
    input  logic               mask_load,
    output logic               event_pending
);

    startup_state_e state_q;
    startup_state_e state_d;
    logic           init_cnt_q;
    logic           init_cnt_d;
    logic           run_s;
    logic           load_s;

    logic [NUM_BTN-1:0] btn_stable_s;
    logic [NUM_BTN-1:0] btn_rise_s;
    logic [NUM_BTN-1:0] btn_fall_s;
    logic [NUM_SW-1:0]  sw_stable_s;
    logic [NUM_SW-1:0]  sw_rise_s;
    logic [NUM_SW-1:0]  sw_fall_s;

    logic [EVT_W-1:0] evt_new_s;
    logic [EVT_W-1:0] event_q;
    logic [EVT_W-1:0] event_d;
    logic [EVT_W-1:0] mask_q;
    logic [EVT_W-1:0] mask_d;
    logic             pending_q;
    logic             pending_d;
    logic             data_unused_s;

    // Startup sequencer next state: two fill cycles, one load cycle, then run forever.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        run_s      = 1'b0;
        load_s     = 1'b0;
        case (state_q)
            INIT: begin
                if (init_cnt_q) begin
                    state_d    = LOAD;
                    init_cnt_d = 1'b0;
                end else begin
                    init_cnt_d = 1'b1;
                end
            end
            LOAD: begin
                load_s  = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                run_s = 1'b1;
            end
            default: begin
                state_d    = INIT;
                init_cnt_d = 1'b0;
            end
        endcase
    end

    // Startup sequencer state register.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state_q    <= INIT;
            init_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .INVERT         (1'b1)
        ) u_cell (
            .sysclk     (sysclk),
            .sysreset_n (sysreset_n),
            .pulse1k    (pulse1k),
            .run        (run_s),
            .load       (load_s),
            .raw        (buttons_raw[i]),
            .stable     (btn_stable_s[i]),
            .rise       (btn_rise_s[i]),
            .fall       (btn_fall_s[i])
        );
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_cell #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .INVERT         (1'b0)
        ) u_cell (
            .sysclk     (sysclk),
            .sysreset_n (sysreset_n),
            .pulse1k    (pulse1k),
            .run        (run_s),
            .load       (load_s),
            .raw        (switches_raw[i]),
            .stable     (sw_stable_s[i]),
            .rise       (sw_rise_s[i]),
            .fall       (sw_fall_s[i])
        );
    end

    // Event, mask and pending next state; a read keeps only this cycle's new events.
    always_comb begin
        evt_new_s = {EVT_W{1'b0}};
        evt_new_s[EVT_PRESS_LSB   +: NUM_BTN] = btn_rise_s;
        evt_new_s[EVT_RELEASE_LSB +: NUM_BTN] = btn_fall_s;
        evt_new_s[EVT_SW_CHANGE]              = |(sw_rise_s | sw_fall_s);
        if (event_read) begin
            event_d = evt_new_s;
        end else begin
            event_d = event_q | evt_new_s;
        end
        if (mask_load) begin
            mask_d = data_in[EVT_W-1:0];
        end else begin
            mask_d = mask_q;
        end
        pending_d = any_pending(event_d, mask_d);
    end

    // Event, mask and pending registers.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            event_q   <= {EVT_W{1'b0}};
            mask_q    <= {EVT_W{1'b0}};
            pending_q <= 1'b0;
        end else begin
            event_q   <= event_d;
            mask_q    <= mask_d;
            pending_q <= pending_d;
        end
    end

    assign data_unused_s = ^data_in[15:EVT_W];

    assign level_out     = {sw_stable_s, 3'b000, btn_stable_s};
    assign event_out     = {9'b0_0000_0000, event_q};
    assign mask_out      = {9'b0_0000_0000, mask_q};
    assign event_pending = pending_q;

endmodule

// File: tb/tb_exp_input_responder.sv
// Scoreboard bench for exp_input_responder with a compressed 1 kHz tick.
module tb_exp_input_responder;

    localparam int TICK_CYC = 20;
    localparam int DB       = 10;

    typedef struct packed {
        logic [15:0] level;
        logic [15:0] evt;
    } exp_t;

    logic        sysclk = 1'b0;
    logic        sysreset_n;
    logic        pulse1k;
    logic [2:0]  buttons_raw;
    logic [9:0]  switches_raw;
    logic [15:0] data_in;
    logic [15:0] level_out;
    logic [15:0] event_out;
    logic        event_read;
    logic [15:0] mask_out;
    logic        mask_load;
    logic        event_pending;

    exp_t sb_q[$];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    bit   tick_en  = 1'b0;
    int   tick_cnt = 0;
    int   phase    = 0;

    exp_input_responder dut (
        .sysclk        (sysclk),
        .sysreset_n    (sysreset_n),
        .pulse1k       (pulse1k),
        .buttons_raw   (buttons_raw),
        .switches_raw  (switches_raw),
        .data_in       (data_in),
        .level_out     (level_out),
        .event_out     (event_out),
        .event_read    (event_read),
        .mask_out      (mask_out),
        .mask_load     (mask_load),
        .event_pending (event_pending)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        pulse1k = 1'b0;
        forever begin
            @(negedge sysclk);
            if (tick_en && phase == TICK_CYC - 1) begin
                pulse1k = 1'b1;
                phase   = 0;
                tick_cnt++;
            end else begin
                pulse1k = 1'b0;
                if (tick_en) phase++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic wait_tick();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 4 * TICK_CYC; i++) begin
            @(posedge sysclk);
            if (pulse1k) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL tick_wait: got no tick, expected one within %0d cycles", 4 * TICK_CYC);
        end
    endtask

    task automatic wait_level_change(input logic [15:0] old_lvl, input int budget,
                                     output int cyc, output bit to);
        cyc = 0;
        to  = 1'b1;
        while (cyc < budget) begin
            @(posedge sysclk);
            #1;
            cyc++;
            if (level_out !== old_lvl) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic pulse_read();
        event_read = 1'b1;
        step(1);
        event_read = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        sysreset_n   = 1'b0;
        switches_raw = 10'h3FF;
        buttons_raw  = 3'b111;
        data_in      = 16'h0000;
        event_read   = 1'b0;
        mask_load    = 1'b0;
        tick_en      = 1'b1;
        step(3);
        n_cmp++;
        if ({level_out, event_out, mask_out, event_pending} !== 49'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got lvl=%h evt=%h mask=%h pend=%b expected all zero",
                     level_out, event_out, mask_out, event_pending);
        end
        @(posedge sysclk);
        #3 sysreset_n = 1'b1;
        sb_q.push_back('{level: 16'hFFC0, evt: 16'h0000});
        step(1);
        n_cmp++;
        if (level_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_init_level: got %h expected %h", level_out, 16'h0000);
        end
        step(3);
        e = sb_q.pop_front();
        n_cmp++;
        if ({level_out, event_out} !== {e.level, e.evt}) begin
            n_fail++;
            $display("FAIL reset_startup: got lvl=%h evt=%h expected lvl=%h evt=%h",
                     level_out, event_out, e.level, e.evt);
        end
    endtask

    task automatic test_press_release();
        exp_t e;
        int   cyc;
        bit   to;
        wait_tick();
        buttons_raw[1] = 1'b0;
        sb_q.push_back('{level: 16'hFFC2, evt: 16'h0002});
        wait_level_change(16'hFFC0, 12 * TICK_CYC, cyc, to);
        e = sb_q.pop_front();
        n_cmp++;
        if (to || {level_out, event_out} !== {e.level, e.evt}) begin
            n_fail++;
            $display("FAIL press: got lvl=%h evt=%h expected lvl=%h evt=%h", level_out, event_out, e.level, e.evt);
        end
        n_cmp++;
        if (cyc != DB * TICK_CYC) begin
            n_fail++;
            $display("FAIL press_latency: got %0d cycles expected %0d", cyc, DB * TICK_CYC);
        end
        n_cmp++;
        if (event_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL press_unmasked_pending: got %b expected 0", event_pending);
        end
        mask_load = 1'b1;
        data_in   = 16'hFF82;
        step(1);
        mask_load = 1'b0;
        n_cmp++;
        if ({mask_out, event_pending} !== {16'h0002, 1'b1}) begin
            n_fail++;
            $display("FAIL mask_load: got mask=%h pend=%b expected mask=0002 pend=1", mask_out, event_pending);
        end
        event_read = 1'b1;
        #1;
        n_cmp++;
        if (event_out !== 16'h0002) begin
            n_fail++;
            $display("FAIL read_during_strobe: got %h expected %h", event_out, 16'h0002);
        end
        step(1);
        event_read = 1'b0;
        n_cmp++;
        if ({event_out, event_pending} !== {16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL read_clear: got evt=%h pend=%b expected evt=0000 pend=0", event_out, event_pending);
        end
        wait_tick();
        buttons_raw[1] = 1'b1;
        sb_q.push_back('{level: 16'hFFC0, evt: 16'h0010});
        wait_level_change(16'hFFC2, 12 * TICK_CYC, cyc, to);
        e = sb_q.pop_front();
        n_cmp++;
        if (to || {level_out, event_out, event_pending} !== {e.level, e.evt, 1'b0}) begin
            n_fail++;
            $display("FAIL release: got lvl=%h evt=%h pend=%b expected lvl=%h evt=%h pend=0",
                     level_out, event_out, event_pending, e.level, e.evt);
        end
        pulse_read();
        wait_tick();
        switches_raw[4] = 1'b0;
        sb_q.push_back('{level: 16'hFBC0, evt: 16'h0040});
        wait_level_change(16'hFFC0, 12 * TICK_CYC, cyc, to);
        e = sb_q.pop_front();
        n_cmp++;
        if (to || {level_out, event_out} !== {e.level, e.evt}) begin
            n_fail++;
            $display("FAIL switch_down: got lvl=%h evt=%h expected lvl=%h evt=%h", level_out, event_out, e.level, e.evt);
        end
        pulse_read();
    endtask

    task automatic test_bounce();
        exp_t e;
        int   cyc;
        bit   to;
        wait_tick();
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                repeat (3) wait_tick();
                n_cmp++;
                if ({level_out, event_out} !== {16'hFBC0, 16'h0000}) begin
                    n_fail++;
                    $display("FAIL bounce_hold_%0d: got lvl=%h evt=%h expected lvl=FBC0 evt=0000", k, level_out, event_out);
                end
            end
            switches_raw[4] = ~switches_raw[4];
        end
        sb_q.push_back('{level: 16'hFFC0, evt: 16'h0040});
        wait_level_change(16'hFBC0, 12 * TICK_CYC, cyc, to);
        e = sb_q.pop_front();
        n_cmp++;
        if (to || {level_out, event_out} !== {e.level, e.evt} || cyc != DB * TICK_CYC) begin
            n_fail++;
            $display("FAIL bounce_settle: got lvl=%h evt=%h after %0d cycles expected lvl=%h evt=%h after %0d",
                     level_out, event_out, cyc, e.level, e.evt, DB * TICK_CYC);
        end
        repeat (15) wait_tick();
        n_cmp++;
        if ({level_out, event_out} !== {16'hFFC0, 16'h0040}) begin
            n_fail++;
            $display("FAIL bounce_single: got lvl=%h evt=%h expected lvl=FFC0 evt=0040", level_out, event_out);
        end
    endtask

    task automatic test_read_race();
        exp_t e;
        wait_tick();
        buttons_raw[0] = 1'b0;
        sb_q.push_back('{level: 16'hFFC1, evt: 16'h0001});
        step(DB * TICK_CYC - 1);
        event_read = 1'b1;
        n_cmp++;
        if ({level_out, event_out} !== {16'hFFC0, 16'h0040}) begin
            n_fail++;
            $display("FAIL race_strobe_cycle: got lvl=%h evt=%h expected lvl=FFC0 evt=0040", level_out, event_out);
        end
        step(1);
        event_read = 1'b0;
        e = sb_q.pop_front();
        n_cmp++;
        if ({level_out, event_out} !== {e.level, e.evt}) begin
            n_fail++;
            $display("FAIL race_after: got lvl=%h evt=%h expected lvl=%h evt=%h", level_out, event_out, e.level, e.evt);
        end
    endtask

    task automatic test_starvation();
        exp_t e;
        int   cyc;
        bit   to;
        int   t0;
        wait_tick();
        t0 = tick_cnt;
        buttons_raw[2] = 1'b0;
        repeat (5) wait_tick();
        tick_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(5 * TICK_CYC);
            n_cmp++;
            if ({level_out, event_out} !== {16'hFFC1, 16'h0001}) begin
                n_fail++;
                $display("FAIL starve_hold_%0d: got lvl=%h evt=%h expected lvl=FFC1 evt=0001", i, level_out, event_out);
            end
        end
        tick_en = 1'b1;
        sb_q.push_back('{level: 16'hFFC5, evt: 16'h0005});
        wait_level_change(16'hFFC1, 8 * TICK_CYC, cyc, to);
        e = sb_q.pop_front();
        n_cmp++;
        if (to || {level_out, event_out} !== {e.level, e.evt}) begin
            n_fail++;
            $display("FAIL starve_resume: got lvl=%h evt=%h expected lvl=%h evt=%h", level_out, event_out, e.level, e.evt);
        end
        n_cmp++;
        if (tick_cnt - t0 != DB || cyc != 5 * TICK_CYC) begin
            n_fail++;
            $display("FAIL starve_ticks: got %0d ticks %0d cycles expected %0d ticks %0d cycles",
                     tick_cnt - t0, cyc, DB, 5 * TICK_CYC);
        end
        mask_load = 1'b1;
        data_in   = 16'h0004;
        step(1);
        mask_load = 1'b0;
        n_cmp++;
        if ({mask_out, event_pending} !== {16'h0004, 1'b1}) begin
            n_fail++;
            $display("FAIL starve_pending: got mask=%h pend=%b expected mask=0004 pend=1", mask_out, event_pending);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        wait_tick();
        switches_raw[0] = 1'b0;
        repeat (5) wait_tick();
        #3 sysreset_n = 1'b0;
        #1;
        n_cmp++;
        if ({level_out, event_out, mask_out, event_pending} !== 49'h0) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got lvl=%h evt=%h mask=%h pend=%b expected all zero",
                     level_out, event_out, mask_out, event_pending);
        end
        @(posedge sysclk);
        #3 sysreset_n = 1'b1;
        sb_q.push_back('{level: 16'hFF85, evt: 16'h0000});
        step(3);
        e = sb_q.pop_front();
        n_cmp++;
        if ({level_out, event_out} !== {e.level, e.evt}) begin
            n_fail++;
            $display("FAIL async_reset_reload: got lvl=%h evt=%h expected lvl=%h evt=%h", level_out, event_out, e.level, e.evt);
        end
        step(15 * TICK_CYC);
        n_cmp++;
        if ({level_out, event_out, event_pending} !== {e.level, e.evt, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset_no_event: got lvl=%h evt=%h pend=%b expected lvl=%h evt=%h pend=0",
                     level_out, event_out, event_pending, e.level, e.evt);
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_read_race();
        test_starvation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/exp_input_responder.md
# exp_input_responder

Expansion-bus responder for the DE0 pushbuttons and slide switches; it answers the register read and load strobes that the MCU's bus expander drives. It synchronizes and debounces 3 buttons and 10 switches using the shared 1 kHz realtime pulse. It exposes a debounced level register, a sticky clear-on-read event register and an event-mask register. It also drives an event-pending flag for the MCU to poll.

## Interface
- NUM_BTN, 3, pushbutton count (raw input active low, 3.3 V pullups)
- NUM_SW, 10, slide switch count (raw input high = up)
- DEBOUNCE_TICKS, 10, consecutive pulse1k ticks an input must disagree with its stable value before it is accepted

Ports:
- sysclk  in  1  system clock (50 MHz)
- sysreset_n  in  1  reset; asynchronous assert, active low
- pulse1k  in  1  one-sysclk-wide 1 kHz tick, already gated by the break mode
- buttons_raw  in  NUM_BTN  raw buttons; 0 = pressed
- switches_raw  in  NUM_SW  raw switches
- data_in  in  16  expansion-bus load data
- level_out  out  16  {switches[9:0], 3'b0, pressed[2:0]}
- event_out  out  16  {9'b0, sw_change, released[2:0], pressed[2:0]}
- event_read  in  1  read strobe for event_out
- mask_out  out  16  {9'b0, mask[6:0]}
- mask_load  in  1  load strobe for mask; loads data_in[6:0]
- event_pending  out  1  |(event[6:0] & mask[6:0]), registered

## Operation
- Each raw input uses a 2-flop synchronizer. Buttons are inverted after sync, so internal 1 = pressed.
- Per-input debounce counter, width $clog2(DEBOUNCE_TICKS+1):
  - synced == stable: counter <= 0.
  - otherwise, on pulse1k: counter increments.
  - Reaching DEBOUNCE_TICKS: stable <= synced and counter <= 0 in the same cycle.
  - Ticks are not required to be consecutive sysclk cycles. Any sysclk cycle with synced == stable clears the counter.
- Startup FSM:
  - INIT: 2 cycles; synchronizers fill, counters are held at 0, no events.
  - LOAD: 1 cycle; stable <= synced for all inputs, no events.
  - RUN: normal operation.
  - The FSM does not leave RUN until reset.
- Event register, 7 bits, sticky:
  - pressed[i]: button i stable 0->1.
  - released[i]: button i stable 1->0.
  - sw_change: any switch stable value changes.
- event_read clears the whole register at the end of the strobe cycle. event_out shows the pre-clear value during the strobe.
- Simultaneous new event and event_read: bits set by that cycle's new events survive; all other bits clear.
- mask_load: mask <= data_in[6:0]. Upper data bits are ignored.
- event_pending uses the mask and event values as they are after the current cycle's updates.
- Reset values:
  - stable = 0, counters = 0, events = 0, mask = 0, FSM = INIT.
  - level_out = 0, event_out = 0, mask_out = 0, event_pending = 0.
- Reset asserted mid-debounce discards all progress. Reset asserted mid-event discards pending events.

## Timing
- Raw edge to synced: 2 sysclk cycles.
- Synced change to stable change: exactly DEBOUNCE_TICKS pulse1k ticks, i.e. 9–10 ms at the defaults, depending on tick phase.
- stable, event bits, mask and event_pending are registered. Each is visible 1 cycle after the causing edge, tick or strobe.
- The first possible event occurs in the 4th cycle after reset release, but only for inputs that change after LOAD.
- While the MCU is halted in break mode, pulse1k stops. Debounce then freezes; it does not reset.

## Structure
- Package exp_input_pkg:
  - Event bit positions: EVT_PRESS_LSB = 0, EVT_RELEASE_LSB = 3, EVT_SW_CHANGE = 6.
  - Register index constants for the expansion address map: EDR_INPUT_LEVEL, EDR_INPUT_EVENT, EDR_INPUT_MASK.
  - FSM state enum: INIT, LOAD, RUN.
- Sub-module debounce_cell, one instance per input (13 total):
  - Contains the synchronizer, counter, stable flop and a one-cycle rise/fall output.
  - Ports: sysclk, sysreset_n, pulse1k, run, load, raw, stable, rise, fall.
- Top-level integration:
  - level_out, event_out and mask_out go onto exp_r.
  - event_read comes from exp_r_read.
  - mask_load comes from exp_r_load.

## Test plan
- **Reset and startup.** Hold switches_raw = 10'h3FF and buttons released through reset. Required: level_out = 16'hFFC0 by cycle 4 after release, and event_out stays 0.
- **Clean press.** Drive buttons_raw[1] low and hold it. Required: level_out[1] = 1 after exactly 10 pulse1k ticks plus sync latency, event_out = 16'h0002, and with mask = 7'h02 loaded, event_pending = 1.
- **Bounce.** Toggle switches_raw[4] every 3 ms for 30 ms, then leave it high. Required: exactly one sw_change, level_out[10] = 1, and it sets 10 ticks after the final toggle.
- **Read-clear race.** With event_out = 16'h0040, assert event_read in the same cycle that button 0's stable value rises. Required: event_out reads 16'h0040 in that cycle and 16'h0001 in the next cycle.
- **Tick starvation.** Hold pulse1k low for 50 ms with button 2 pressed. Required: no level change and no events. Resuming ticks completes the debounce after the remaining tick count.
- **Async reset mid-debounce.** Pulse sysreset_n low for 1 cycle at tick 5 of a debounce. Required: all outputs go to 0 immediately, the FSM re-runs INIT/LOAD, and the held input appears in level_out after LOAD without generating an event.
